// File: rtl/tap_controller.sv
`timescale 1ns/1ps
// tap_controller
//   IEEE 1149.1 TAP controller. A 16-state FSM clocked by TCK and steered by
//   TMS. It drives the control signals for the instruction register cells
//   (ShiftIR, ClockIR, UpdateIR, Reset) and the data register equivalents.
//   It also drives the TDO mux select and the TDO driver enable.
//
// Parameters
//   GATE_CLOCKS  1: ClockIR/ClockDR/UpdateIR/UpdateDR are gated clocks
//                0: the same four signals are plain level enables
//
// Ports
//   TCK       in   test clock (the only clock)
//   TRSTn     in   asynchronous, active-low reset
//   TMS       in   mode select, sampled on rising TCK
//   TapState  out  [3:0] current state code; also serves as the debug view of the FSM
//   Reset     out  active-high IR/DR reset, high while in Test-Logic-Reset
//   ShiftIR   out  IR cell shift select
//   ClockIR   out  IR capture/shift clock (or enable)
//   UpdateIR  out  IR update clock (or enable)
//   ShiftDR   out  DR shift select
//   ClockDR   out  DR capture/shift clock (or enable)
//   UpdateDR  out  DR update clock (or enable)
//   Select    out  TDO mux select: 1 = IR path, 0 = DR path
//   Enable    out  TDO driver enable
module tap_controller #(
  parameter bit GATE_CLOCKS = 1'b1
) (
  input  logic       TCK,
  input  logic       TRSTn,
  input  logic       TMS,
  output logic [3:0] TapState,
  output logic       Reset,
  output logic       ShiftIR,
  output logic       ClockIR,
  output logic       UpdateIR,
  output logic       ShiftDR,
  output logic       ClockDR,
  output logic       UpdateDR,
  output logic       Select,
  output logic       Enable
);

  // State codes are the standard 1149.1 encoding. Bit 3 is set for every
  // IR-side state and for TLR/RTI, so it doubles as the TDO mux select.
  localparam logic [3:0] ST_EX2DR = 4'h0;
  localparam logic [3:0] ST_EX1DR = 4'h1;
  localparam logic [3:0] ST_SHDR  = 4'h2;
  localparam logic [3:0] ST_PAUDR = 4'h3;
  localparam logic [3:0] ST_SELIR = 4'h4;
  localparam logic [3:0] ST_UPDDR = 4'h5;
  localparam logic [3:0] ST_CAPDR = 4'h6;
  localparam logic [3:0] ST_SELDR = 4'h7;
  localparam logic [3:0] ST_EX2IR = 4'h8;
  localparam logic [3:0] ST_EX1IR = 4'h9;
  localparam logic [3:0] ST_SHIR  = 4'hA;
  localparam logic [3:0] ST_PAUIR = 4'hB;
  localparam logic [3:0] ST_RTI   = 4'hC;
  localparam logic [3:0] ST_UPDIR = 4'hD;
  localparam logic [3:0] ST_CAPIR = 4'hE;
  localparam logic [3:0] ST_TLR   = 4'hF;

  logic [3:0] state;
  logic [3:0] next_state;

  // Registers updated on falling TCK. They change half a cycle after the state
  // register, so they are glitch-free while TCK is high.
  logic reset_q;
  logic shift_ir_q;
  logic shift_dr_q;
  logic enable_q;
  logic gate_ir_q;
  logic gate_dr_q;

  // State decodes
  logic in_tlr;
  logic in_shir;
  logic in_shdr;
  logic in_updir;
  logic in_upddr;
  logic in_capsh_ir;
  logic in_capsh_dr;

  assign in_tlr      = (state == ST_TLR);
  assign in_shir     = (state == ST_SHIR);
  assign in_shdr     = (state == ST_SHDR);
  assign in_updir    = (state == ST_UPDIR);
  assign in_upddr    = (state == ST_UPDDR);
  assign in_capsh_ir = (state == ST_CAPIR) || (state == ST_SHIR);
  assign in_capsh_dr = (state == ST_CAPDR) || (state == ST_SHDR);

  // Next-state logic. All 16 codes are in use. The default arm only guards
  // against X or corruption and returns the FSM to TLR.
  always_comb begin
    next_state = ST_TLR;
    case (state)
      ST_TLR:   next_state = TMS ? ST_TLR   : ST_RTI;
      ST_RTI:   next_state = TMS ? ST_SELDR : ST_RTI;
      ST_SELDR: next_state = TMS ? ST_SELIR : ST_CAPDR;
      ST_SELIR: next_state = TMS ? ST_TLR   : ST_CAPIR;
      ST_CAPDR: next_state = TMS ? ST_EX1DR : ST_SHDR;
      ST_SHDR:  next_state = TMS ? ST_EX1DR : ST_SHDR;
      ST_EX1DR: next_state = TMS ? ST_UPDDR : ST_PAUDR;
      ST_PAUDR: next_state = TMS ? ST_EX2DR : ST_PAUDR;
      ST_EX2DR: next_state = TMS ? ST_UPDDR : ST_SHDR;
      ST_UPDDR: next_state = TMS ? ST_SELDR : ST_RTI;
      ST_CAPIR: next_state = TMS ? ST_EX1IR : ST_SHIR;
      ST_SHIR:  next_state = TMS ? ST_EX1IR : ST_SHIR;
      ST_EX1IR: next_state = TMS ? ST_UPDIR : ST_PAUIR;
      ST_PAUIR: next_state = TMS ? ST_EX2IR : ST_PAUIR;
      ST_EX2IR: next_state = TMS ? ST_UPDIR : ST_SHIR;
      ST_UPDIR: next_state = TMS ? ST_SELDR : ST_RTI;
      default:  next_state = ST_TLR;
    endcase
  end

  always_ff @(posedge TCK or negedge TRSTn) begin
    if (!TRSTn) begin
      state <= ST_TLR;
    end else begin
      state <= next_state;
    end
  end

  // The gate_* registers hold the clock gates for the capture/shift clocks.
  // They are loaded while TCK is low, so TCK | ~gate cannot glitch during the
  // high phase. The gated clock therefore rises with the TCK edge that leaves
  // Capture or Shift.
  always_ff @(negedge TCK or negedge TRSTn) begin
    if (!TRSTn) begin
      reset_q    <= 1'b1;
      shift_ir_q <= 1'b0;
      shift_dr_q <= 1'b0;
      enable_q   <= 1'b0;
      gate_ir_q  <= 1'b0;
      gate_dr_q  <= 1'b0;
    end else begin
      reset_q    <= in_tlr;
      shift_ir_q <= in_shir;
      shift_dr_q <= in_shdr;
      enable_q   <= in_shir || in_shdr;
      gate_ir_q  <= in_capsh_ir;
      gate_dr_q  <= in_capsh_dr;
    end
  end

  assign TapState = state;
  assign Reset    = reset_q;
  assign ShiftIR  = shift_ir_q;
  assign ShiftDR  = shift_dr_q;
  assign Enable   = enable_q;
  assign Select   = state[3];

  generate
    if (GATE_CLOCKS) begin : g_gated
      // Capture/shift clocks idle high. They pull low during the low phase
      // of TCK while gated in.
      assign ClockIR  = TCK | ~gate_ir_q;
      assign ClockDR  = TCK | ~gate_dr_q;
      // Update pulses fill the low half of the TCK cycle spent in Update.
      // Their rising edge is the falling TCK inside Update. TRSTn forces the
      // state to TLR, so a reset mid-shift cannot produce an update edge.
      assign UpdateIR = ~TCK & in_updir;
      assign UpdateDR = ~TCK & in_upddr;
    end else begin : g_level
      assign ClockIR  = in_capsh_ir;
      assign ClockDR  = in_capsh_dr;
      assign UpdateIR = in_updir;
      assign UpdateDR = in_upddr;
    end
  endgenerate

endmodule

// File: tb/tb_tap_controller.sv
`timescale 1ns/1ps
module tb_tap_controller;

  logic TCK;
  logic TRSTn;
  logic TMS;

  // Outputs of the gated-clock instance (_g) and the level instance (_l)
  logic [3:0] tap_state_g, tap_state_l;
  logic reset_g, shift_ir_g, clock_ir_g, update_ir_g, shift_dr_g, clock_dr_g, update_dr_g, select_g, enable_g;
  logic reset_l, shift_ir_l, clock_ir_l, update_ir_l, shift_dr_l, clock_dr_l, update_dr_l, select_l, enable_l;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_q[$];
  logic [3:0] e;

  // Samples taken inside drive_tms
  logic ck_hi_ir_g, ck_hi_dr_g;
  int   upd_ir_lo_g, upd_ir_lo_l, upd_ir_hi_g;
  int   upd_dr_lo_g;

  // Reference transition tables, indexed by state code
  logic [3:0] nxt0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                            4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
  logic [3:0] nxt1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                            4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

  tap_controller #(.GATE_CLOCKS(1'b1)) dut_g (
    .TCK(TCK), .TRSTn(TRSTn), .TMS(TMS), .TapState(tap_state_g),
    .Reset(reset_g), .ShiftIR(shift_ir_g), .ClockIR(clock_ir_g), .UpdateIR(update_ir_g),
    .ShiftDR(shift_dr_g), .ClockDR(clock_dr_g), .UpdateDR(update_dr_g),
    .Select(select_g), .Enable(enable_g)
  );

  tap_controller #(.GATE_CLOCKS(1'b0)) dut_l (
    .TCK(TCK), .TRSTn(TRSTn), .TMS(TMS), .TapState(tap_state_l),
    .Reset(reset_l), .ShiftIR(shift_ir_l), .ClockIR(clock_ir_l), .UpdateIR(update_ir_l),
    .ShiftDR(shift_dr_l), .ClockDR(clock_dr_l), .UpdateDR(update_dr_l),
    .Select(select_l), .Enable(enable_l)
  );

  // Clock and reset
  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Driver: call with TCK low, just after a falling edge. Applies TMS, crosses
  // one rising edge, and returns 1 time unit after the following falling edge.
  task automatic drive_tms(input logic v);
    TMS = v;
    @(posedge TCK);
    #1;
    ck_hi_ir_g = clock_ir_g;
    ck_hi_dr_g = clock_dr_g;
    if (update_ir_g) upd_ir_hi_g++;
    @(negedge TCK);
    #1;
    if (update_ir_g) upd_ir_lo_g++;
    if (update_ir_l) upd_ir_lo_l++;
    if (update_dr_g) upd_dr_lo_g++;
  endtask

  task automatic test_reset();
    TMS   = 1'b1;
    TRSTn = 1'b0;
    #1;
    total++; if (tap_state_g !== 4'hF) begin bad++; $display("FAIL rst_state_g: got %h want f", tap_state_g); end
    total++; if (tap_state_l !== 4'hF) begin bad++; $display("FAIL rst_state_l: got %h want f", tap_state_l); end
    total++; if ({reset_g, shift_ir_g, shift_dr_g, enable_g, select_g} !== 5'b10001) begin
      bad++; $display("FAIL rst_flags: got %b want 10001", {reset_g, shift_ir_g, shift_dr_g, enable_g, select_g}); end
    total++; if ({clock_ir_g, clock_dr_g, update_ir_g, update_dr_g} !== 4'b1100) begin
      bad++; $display("FAIL rst_clk_g: got %b want 1100", {clock_ir_g, clock_dr_g, update_ir_g, update_dr_g}); end
    total++; if ({clock_ir_l, clock_dr_l, update_ir_l, update_dr_l} !== 4'b0000) begin
      bad++; $display("FAIL rst_clk_l: got %b want 0000", {clock_ir_l, clock_dr_l, update_ir_l, update_dr_l}); end
    repeat (2) @(negedge TCK);
    #1;
    TRSTn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(4'hF);
      drive_tms(1'b1);
      e = exp_q.pop_front();
      total++; if (tap_state_g !== e) begin bad++; $display("FAIL hold_tlr_state: got %h want %h", tap_state_g, e); end
      total++; if ({reset_g, select_g, enable_g} !== 3'b110) begin
        bad++; $display("FAIL hold_tlr_flags: got %b want 110", {reset_g, select_g, enable_g}); end
    end
  endtask

  task automatic test_ir_entry();
    logic       tv [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] sv [5] = '{4'hC, 4'h7, 4'h4, 4'hE, 4'hA};
    logic       in_cs;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(sv[i]);
      drive_tms(tv[i]);
      e = exp_q.pop_front();
      in_cs = (e == 4'hE) || (e == 4'hA);
      total++; if (tap_state_g !== e) begin bad++; $display("FAIL ir_entry_state_g: got %h want %h", tap_state_g, e); end
      total++; if (tap_state_l !== e) begin bad++; $display("FAIL ir_entry_state_l: got %h want %h", tap_state_l, e); end
      total++; if (shift_ir_g !== (e == 4'hA)) begin bad++; $display("FAIL ir_entry_shiftir: got %b want %b", shift_ir_g, e == 4'hA); end
      total++; if (enable_g !== (e == 4'hA)) begin bad++; $display("FAIL ir_entry_enable: got %b want %b", enable_g, e == 4'hA); end
      total++; if (clock_ir_g !== !in_cs) begin bad++; $display("FAIL ir_entry_clkir_low_g: got %b want %b", clock_ir_g, !in_cs); end
      total++; if (ck_hi_ir_g !== 1'b1) begin bad++; $display("FAIL ir_entry_clkir_high_g: got %b want 1", ck_hi_ir_g); end
      total++; if (clock_ir_l !== in_cs) begin bad++; $display("FAIL ir_entry_clkir_level: got %b want %b", clock_ir_l, in_cs); end
      total++; if (clock_dr_l !== 1'b0) begin bad++; $display("FAIL ir_entry_clkdr_level: got %b want 0", clock_dr_l); end
    end
  endtask

  task automatic test_ir_shift();
    logic       tv [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] sv [6] = '{4'hA, 4'hA, 4'hA, 4'h9, 4'hD, 4'hC};
    upd_ir_lo_g = 0; upd_ir_lo_l = 0; upd_ir_hi_g = 0;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(sv[i]);
      drive_tms(tv[i]);
      e = exp_q.pop_front();
      total++; if (tap_state_g !== e) begin bad++; $display("FAIL ir_shift_state: got %h want %h", tap_state_g, e); end
      total++; if (shift_ir_g !== (e == 4'hA)) begin bad++; $display("FAIL ir_shift_shiftir: got %b want %b", shift_ir_g, e == 4'hA); end
      total++; if (select_g !== 1'b1) begin bad++; $display("FAIL ir_shift_select: got %b want 1", select_g); end
    end
    total++; if (upd_ir_lo_g != 1) begin bad++; $display("FAIL ir_update_pulses_g: got %0d want 1", upd_ir_lo_g); end
    total++; if (upd_ir_hi_g != 0) begin bad++; $display("FAIL ir_update_high_phase_g: got %0d want 0", upd_ir_hi_g); end
    total++; if (upd_ir_lo_l != 1) begin bad++; $display("FAIL ir_update_level_l: got %0d want 1", upd_ir_lo_l); end
  endtask

  task automatic test_dr_path();
    logic       tv [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] sv [9] = '{4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0, 4'h2, 4'h1, 4'h5};
    logic       in_cs;
    upd_dr_lo_g = 0;
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(sv[i]);
      drive_tms(tv[i]);
      e = exp_q.pop_front();
      in_cs = (e == 4'h6) || (e == 4'h2);
      total++; if (tap_state_g !== e) begin bad++; $display("FAIL dr_state: got %h want %h", tap_state_g, e); end
      total++; if ({select_g, select_l} !== 2'b00) begin bad++; $display("FAIL dr_select: got %b want 00", {select_g, select_l}); end
      total++; if (shift_dr_g !== (e == 4'h2)) begin bad++; $display("FAIL dr_shiftdr: got %b want %b", shift_dr_g, e == 4'h2); end
      total++; if (enable_g !== (e == 4'h2)) begin bad++; $display("FAIL dr_enable: got %b want %b", enable_g, e == 4'h2); end
      total++; if (clock_dr_g !== !in_cs) begin bad++; $display("FAIL dr_clkdr_low_g: got %b want %b", clock_dr_g, !in_cs); end
      total++; if (ck_hi_dr_g !== 1'b1) begin bad++; $display("FAIL dr_clkdr_high_g: got %b want 1", ck_hi_dr_g); end
      total++; if (clock_dr_l !== in_cs) begin bad++; $display("FAIL dr_clkdr_level: got %b want %b", clock_dr_l, in_cs); end
      total++; if (update_dr_l !== (e == 4'h5)) begin bad++; $display("FAIL dr_upddr_level: got %b want %b", update_dr_l, e == 4'h5); end
    end
    total++; if (upd_dr_lo_g != 1) begin bad++; $display("FAIL dr_update_pulses_g: got %0d want 1", upd_dr_lo_g); end
  endtask

  task automatic test_pause_to_tlr();
    logic       tv [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] sv [9] = '{4'h7, 4'h6, 4'h1, 4'h3, 4'h0, 4'h5, 4'h7, 4'h4, 4'hF};
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(sv[i]);
      drive_tms(tv[i]);
      e = exp_q.pop_front();
      total++; if (tap_state_g !== e) begin bad++; $display("FAIL pause_tlr_state: got %h want %h", tap_state_g, e); end
    end
    total++; if (reset_g !== 1'b1) begin bad++; $display("FAIL pause_tlr_reset: got %b want 1", reset_g); end
  endtask

  task automatic test_trst_mid_shift();
    logic tv [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) drive_tms(tv[i]);
    total++; if ({tap_state_g, shift_ir_g} !== 5'b1010_1) begin
      bad++; $display("FAIL trst_setup: got %h/%b want a/1", tap_state_g, shift_ir_g); end
    upd_ir_lo_g = 0; upd_ir_hi_g = 0;
    TRSTn = 1'b0;
    #1;
    total++; if (tap_state_g !== 4'hF || tap_state_l !== 4'hF) begin
      bad++; $display("FAIL trst_state: got %h/%h want f/f", tap_state_g, tap_state_l); end
    total++; if ({reset_g, shift_ir_g, enable_g, select_g} !== 4'b1001) begin
      bad++; $display("FAIL trst_flags: got %b want 1001", {reset_g, shift_ir_g, enable_g, select_g}); end
    total++; if ({clock_ir_g, clock_ir_l, update_ir_g, update_ir_l} !== 4'b1000) begin
      bad++; $display("FAIL trst_clocks: got %b want 1000", {clock_ir_g, clock_ir_l, update_ir_g, update_ir_l}); end
    @(posedge TCK);
    #1;
    total++; if (update_ir_g !== 1'b0) begin bad++; $display("FAIL trst_upd_high: got %b want 0", update_ir_g); end
    @(negedge TCK);
    #1;
    total++; if (update_ir_g !== 1'b0) begin bad++; $display("FAIL trst_upd_low: got %b want 0", update_ir_g); end
    TRSTn = 1'b1;
    exp_q.push_back(4'hF);
    drive_tms(1'b1);
    e = exp_q.pop_front();
    total++; if (tap_state_g !== e) begin bad++; $display("FAIL trst_release_state: got %h want %h", tap_state_g, e); end
    total++; if (upd_ir_lo_g + upd_ir_hi_g != 0) begin
      bad++; $display("FAIL trst_no_update: got %0d want 0", upd_ir_lo_g + upd_ir_hi_g); end
  endtask

  task automatic test_random_walk();
    logic [3:0] cur;
    logic       t;
    cur = 4'hF;
    for (int i = 0; i < 80; i++) begin
      t = 1'($urandom_range(0, 1));
      cur = t ? nxt1[cur] : nxt0[cur];
      exp_q.push_back(cur);
      drive_tms(t);
      e = exp_q.pop_front();
      total++; if (tap_state_g !== e || tap_state_l !== e) begin
        bad++; $display("FAIL rand_state: got %h/%h want %h", tap_state_g, tap_state_l, e); end
      total++; if ({reset_g, enable_g, select_g} !== {e == 4'hF, (e == 4'hA) || (e == 4'h2), e[3]}) begin
        bad++; $display("FAIL rand_flags: got %b want %b", {reset_g, enable_g, select_g},
                        {e == 4'hF, (e == 4'hA) || (e == 4'h2), e[3]}); end
    end
    for (int i = 0; i < 5; i++) drive_tms(1'b1);
    total++; if (tap_state_g !== 4'hF) begin bad++; $display("FAIL rand_five_ones: got %h want f", tap_state_g); end
  endtask

  initial begin
    TMS   = 1'b1;
    TRSTn = 1'b1;
    ck_hi_ir_g = 1'b0; ck_hi_dr_g = 1'b0;
    upd_ir_lo_g = 0; upd_ir_lo_l = 0; upd_ir_hi_g = 0; upd_dr_lo_g = 0;
    @(negedge TCK);
    #1;
    test_reset();
    test_ir_entry();
    test_ir_shift();
    test_dr_path();
    test_pause_to_tlr();
    test_trst_mid_shift();
    test_random_walk();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_drain: got %0d want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
